// File: rtl/ascii_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ascii_dec_pkg
// Purpose  : Shared FSM state encoding and ASCII constants for the
//            ASCII-decimal accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package ascii_dec_pkg;

  // Converter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;

endpackage
`default_nettype wire

// File: rtl/ascii_digit_classify.sv
`default_nettype none
// ============================================================================
// Module   : ascii_digit_classify
// Purpose  : Combinational character classifier: decimal digit (with its
//            value) or terminator. Anything else is a bad character.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_digit_classify
  import ascii_dec_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = ASCII_CR
) (
  input  logic [7:0] i_ascii_in,
  output logic       o_is_digit,
  output logic [3:0] o_digit,
  output logic       o_is_term
);

  logic [7:0] w_offset;

  // Range check against '0'..'9'; the digit value is the offset from '0'
  always_comb begin
    w_offset   = i_ascii_in - ASCII_0;
    o_is_digit = (i_ascii_in >= ASCII_0) && (i_ascii_in <= ASCII_9);
    o_digit    = w_offset[3:0];
    o_is_term  = (i_ascii_in == TERM_CHAR);
  end

endmodule
`default_nettype wire

// File: rtl/ascii_dec_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : ascii_dec_accumulator
// Purpose  : Serial ASCII-decimal to binary converter. Accumulates digits as
//            value*10 + digit and emits one registered result, with an error
//            flag, each time the terminator character is received.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_dec_accumulator
  import ascii_dec_pkg::*;
#(
  parameter int         OUT_W      = 20,
  parameter int         MAX_DIGITS = 5,
  parameter logic [7:0] TERM_CHAR  = 8'h0D
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        i_ascii_in,
  input  logic                              i_ascii_valid,
  output logic                              o_ascii_ready,
  output logic [OUT_W-1:0]                  o_bin_out,
  output logic                              o_bin_valid,
  input  logic                              i_bin_ready,
  output logic                              o_error,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   o_digit_count
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  // Four guard bits so acc*10+9 never wraps before the range check
  localparam int AW = OUT_W + 4;
  localparam logic [AW-1:0] MAX_VAL = {4'b0000, {OUT_W{1'b1}}};
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t          r_state;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_count;

  logic            w_is_digit;
  logic [3:0]      w_digit;
  logic            w_is_term;
  logic            w_xfer;
  logic [AW-1:0]   w_mul10;
  logic [AW-1:0]   w_sum;
  logic            w_ovf;

  ascii_digit_classify #(
    .TERM_CHAR (TERM_CHAR)
  ) u_classify (
    .i_ascii_in (i_ascii_in),
    .o_is_digit (w_is_digit),
    .o_digit    (w_digit),
    .o_is_term  (w_is_term)
  );

  // Handshake, shift-add times-ten and overflow detection on the full-width sum
  always_comb begin
    o_ascii_ready = (r_state != DONE);
    w_xfer        = i_ascii_valid && o_ascii_ready;
    w_mul10       = (r_acc << 3) + (r_acc << 1);
    w_sum         = w_mul10 + AW'(w_digit);
    w_ovf         = (r_count == MAX_CNT) || (w_sum > MAX_VAL);
  end

  // Converter FSM with accumulator and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_acc         <= '0;
      r_count       <= '0;
      o_bin_out     <= '0;
      o_bin_valid   <= 1'b0;
      o_error       <= 1'b0;
      o_digit_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (w_is_digit) begin
              r_acc   <= AW'(w_digit);
              r_count <= CNT_ONE;
              r_state <= ACCUM;
            end else if (!w_is_term) begin
              r_state <= FLUSH;
            end
            // A terminator here is an empty line and is dropped silently
          end
        end

        ACCUM: begin
          if (w_xfer) begin
            if (w_is_digit) begin
              if (w_ovf) begin
                r_state <= FLUSH;
              end else begin
                r_acc   <= w_sum;
                r_count <= r_count + CNT_ONE;
              end
            end else if (w_is_term) begin
              o_bin_out     <= r_acc[OUT_W-1:0];
              o_error       <= 1'b0;
              o_digit_count <= r_count;
              o_bin_valid   <= 1'b1;
              r_state       <= DONE;
            end else begin
              r_state <= FLUSH;
            end
          end
        end

        FLUSH: begin
          // Count is frozen at the failure point; only the terminator matters
          if (w_xfer && w_is_term) begin
            o_bin_out     <= '0;
            o_error       <= 1'b1;
            o_digit_count <= r_count;
            o_bin_valid   <= 1'b1;
            r_state       <= DONE;
          end
        end

        DONE: begin
          if (i_bin_ready) begin
            o_bin_valid <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascii_dec_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascii_dec_accumulator
// Purpose  : Self-checking bench for ascii_dec_accumulator. Instance u_def uses
//            default parameters, u_m7 uses MAX_DIGITS=7 to reach the value limit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascii_dec_accumulator;

  localparam logic [7:0] CR = 8'h0D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a_in;
  logic        a_valid;
  logic        b_ready;
  logic        sel;     // 0 selects u_def, 1 selects u_m7

  logic        d_ready, d_bv, d_err;
  logic [19:0] d_out;
  logic [2:0]  d_cnt;
  logic        m_ready, m_bv, m_err;
  logic [19:0] m_out;
  logic [3:0]  m_cnt;

  logic        w_ready, w_bv, w_err;
  logic [19:0] w_out;
  logic [3:0]  w_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ascii_dec_accumulator u_def (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_ascii_in    (a_in),
    .i_ascii_valid (a_valid & ~sel),
    .o_ascii_ready (d_ready),
    .o_bin_out     (d_out),
    .o_bin_valid   (d_bv),
    .i_bin_ready   (b_ready & ~sel),
    .o_error       (d_err),
    .o_digit_count (d_cnt)
  );

  ascii_dec_accumulator #(
    .OUT_W      (20),
    .MAX_DIGITS (7),
    .TERM_CHAR  (8'h0D)
  ) u_m7 (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_ascii_in    (a_in),
    .i_ascii_valid (a_valid & sel),
    .o_ascii_ready (m_ready),
    .o_bin_out     (m_out),
    .o_bin_valid   (m_bv),
    .i_bin_ready   (b_ready & sel),
    .o_error       (m_err),
    .o_digit_count (m_cnt)
  );

  assign w_ready = sel ? m_ready : d_ready;
  assign w_bv    = sel ? m_bv    : d_bv;
  assign w_err   = sel ? m_err   : d_err;
  assign w_out   = sel ? m_out   : d_out;
  assign w_cnt   = sel ? m_cnt   : {1'b0, d_cnt};

  typedef struct {
    bit          s;
    string       str;
    logic [19:0] v;
    logic        e;
    logic [3:0]  c;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Present one character from a negedge; returns at the negedge after it transfers
  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    a_in = c;
    a_valid = 1'b1;
    while (!w_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total_cnt++;
      $display("FAIL handshake_timeout: ready stuck at %0b expected 1", w_ready);
    end
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    chk({"pre_term_valid ", s}, 32'(w_bv), 32'd0);
    send_char(CR);
  endtask

  task automatic check_result(input string nm, input logic [19:0] v, input logic e, input logic [3:0] c);
    chk({nm, " bin_valid"}, 32'(w_bv), 32'd1);
    chk({nm, " bin_out"}, 32'(w_out), 32'(v));
    chk({nm, " error"}, 32'(w_err), 32'(e));
    chk({nm, " digit_count"}, 32'(w_cnt), 32'(c));
    chk({nm, " ready_low"}, 32'(w_ready), 32'd0);
    if (b_ready) begin
      @(negedge clk);
      chk({nm, " valid_1cyc"}, 32'(w_bv), 32'd0);
      chk({nm, " ready_back"}, 32'(w_ready), 32'd1);
    end
  endtask

  task automatic check_reset_outs(input string nm);
    chk({nm, " bin_valid"}, 32'(d_bv), 32'd0);
    chk({nm, " bin_out"}, 32'(d_out), 32'd0);
    chk({nm, " error"}, 32'(d_err), 32'd0);
    chk({nm, " digit_count"}, 32'(d_cnt), 32'd0);
    chk({nm, " ascii_ready"}, 32'(d_ready), 32'd1);
  endtask

  initial begin
    tbl[0] = '{1'b0, "1234",    20'h004D2, 1'b0, 4'd4};
    tbl[1] = '{1'b0, "12a4",    20'h00000, 1'b1, 4'd2};
    tbl[2] = '{1'b0, "7",       20'h00007, 1'b0, 4'd1};
    tbl[3] = '{1'b0, "123456",  20'h00000, 1'b1, 4'd5};
    tbl[4] = '{1'b0, "x5",      20'h00000, 1'b1, 4'd0};
    tbl[5] = '{1'b0, "00042",   20'h0002A, 1'b0, 4'd5};
    tbl[6] = '{1'b1, "1048575", 20'hFFFFF, 1'b0, 4'd7};
    tbl[7] = '{1'b1, "1048576", 20'h00000, 1'b1, 4'd6};
    tbl[8] = '{1'b1, "9999999", 20'h00000, 1'b1, 4'd6};

    rst_n = 1'b0; a_in = 8'h00; a_valid = 1'b0; b_ready = 1'b1; sel = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      sel = tbl[i].s;
      send_line(tbl[i].str);
      check_result(tbl[i].str, tbl[i].v, tbl[i].e, tbl[i].c);
    end
    sel = 1'b0;

    // Backpressure: result held, extra character offered but not taken
    b_ready = 1'b0;
    send_line("99999");
    check_result("bp", 20'h1869F, 1'b0, 4'd5);
    a_in = 8'h38;
    a_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp hold valid", 32'(w_bv), 32'd1);
      chk("bp hold out", 32'(w_out), 32'h1869F);
      chk("bp hold ready", 32'(w_ready), 32'd0);
    end
    a_valid = 1'b0;
    b_ready = 1'b1;
    @(negedge clk);
    chk("bp release valid", 32'(w_bv), 32'd0);
    chk("bp release ready", 32'(w_ready), 32'd1);
    send_line("5");
    check_result("after_bp", 20'h00005, 1'b0, 4'd1);

    // Empty lines produce nothing
    send_char(CR);
    chk("empty1 valid", 32'(w_bv), 32'd0);
    send_char(CR);
    chk("empty2 valid", 32'(w_bv), 32'd0);
    @(negedge clk);
    chk("empty3 valid", 32'(w_bv), 32'd0);
    send_line("3");
    check_result("after_empty", 20'h00003, 1'b0, 4'd1);

    // Reset mid-number discards the partial value
    send_char(8'h31);
    send_char(8'h32);
    rst_n = 1'b0;
    #1;
    check_reset_outs("midreset_async");
    repeat (2) @(negedge clk);
    check_reset_outs("midreset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    send_line("7");
    check_result("after_reset", 20'h00007, 1'b0, 4'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ascii_dec_accumulator.md
# ascii_dec_accumulator

Sequential, parametrised ASCII-decimal-to-binary converter for the serial command front end. It consumes a stream of ASCII characters one per cycle over a valid/ready handshake and accumulates decimal digits as value = value*10 + digit. When it sees a terminator character, it emits one registered binary result with an error flag. It sits between the UART receive path and the command decoder, and replaces the per-digit-weight lookup decoders with one block that handles any digit count up to MAX_DIGITS.

## Interface
- OUT_W, default 20: result width in bits.
- MAX_DIGITS, default 5: maximum digits accepted per number.
- TERM_CHAR, default 8'h0D: terminator character (CR).
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ascii_in  in  8  input character.
- ascii_valid  in  1  ascii_in is valid this cycle.
- ascii_ready  out  1  block accepts a character this cycle.
- bin_out  out  OUT_W  converted value; 0 when error is 1.
- bin_valid  out  1  bin_out/error/digit_count are valid.
- bin_ready  in  1  downstream consumes the result.
- error  out  1  result invalid (bad character or overflow).
- digit_count  out  $clog2(MAX_DIGITS+1)  number of digits accepted for this result.

## Operation
- Characters are classified as follows:
  - digit: 8'h30–8'h39.
  - terminator: TERM_CHAR.
  - anything else: bad.
- A character transfers when ascii_valid && ascii_ready at a rising edge.
- State machine:
  - IDLE
    - digit: acc = digit, count = 1, go to ACCUM.
    - terminator: discarded; empty line, no result.
    - bad: go to FLUSH.
  - ACCUM
    - digit with count == MAX_DIGITS, or acc*10+digit > 2^OUT_W−1: go to FLUSH (overflow).
    - other digit: acc = acc*10+digit, count += 1.
    - terminator: load bin_out = acc, error = 0, digit_count = count; go to DONE.
    - bad: go to FLUSH.
  - FLUSH
    - digits and bad characters: discarded.
    - terminator: load bin_out = 0, error = 1, digit_count = count at the failure point; go to DONE.
  - DONE
    - bin_valid = 1 and ascii_ready = 0.
    - bin_ready: clear bin_valid, acc and count; go to IDLE.
- ascii_ready = (state != DONE), decoded combinationally from the state register.
- Arithmetic:
  - acc is OUT_W+4 bits wide.
  - The multiply is acc*10 = (acc<<3)+(acc<<1).
  - Overflow is compared against the full-width sum before truncation.
  - No multiplier primitive is used.

## Timing
- Reset values:
  - state IDLE; acc 0; count 0.
  - bin_out 0; bin_valid 0; error 0; digit_count 0.
  - ascii_ready is 1 while in reset, because the state is IDLE.
- Throughput is one character per cycle with no bubbles between digits.
- Latency: bin_valid rises the cycle after the terminator is accepted.
- Output holding:
  - Outputs stay stable while bin_valid && !bin_ready.
  - bin_valid falls the cycle after bin_ready is sampled high.
  - ascii_ready rises that same cycle.
- Minimum spacing between consecutive results is terminator + 1 cycle, with bin_ready held high.
- Reset assertion mid-number aborts the number immediately; no result is produced.
- bin_ready while bin_valid is 0 is ignored.
- The value 2^OUT_W−1 is accepted exactly; the next larger value is an error.

## Structure
- Package ascii_dec_pkg holds:
  - state enum: IDLE, ACCUM, FLUSH, DONE.
  - constants: ASCII_0 = 8'h30, ASCII_9 = 8'h39, ASCII_CR = 8'h0D.
- Sub-module ascii_digit_classify, combinational:
  - input: ascii_in.
  - outputs: is_digit, digit[3:0], is_term (TERM_CHAR passed as a parameter).
- The top level holds the FSM, the accumulator datapath and the output registers.

## Test plan
- Basic conversion, defaults: "1234\r" streamed back-to-back with bin_ready=1 -> bin_out=20'h004D2, error=0, digit_count=4, bin_valid exactly 1 cycle, rising 1 cycle after the CR.
- Bad character: "12a4\r" -> bin_out=0, error=1, digit_count=2; '4' is discarded; next "7\r" -> bin_out=7, error=0.
- Overflow, OUT_W=20, MAX_DIGITS=7:
  - "1048575\r" -> 20'hFFFFF, error=0.
  - "1048576\r" -> error=1, bin_out=0.
  - Defaults, "123456\r" -> error=1 (digit limit).
- Backpressure: hold bin_ready=0 for 5 cycles after "99999\r":
  - bin_out=20'h1869F stays stable.
  - ascii_ready=0 and incoming ascii_valid characters are not consumed.
  - After bin_ready pulses, the next "5\r" -> 5.
- Empty line and reset:
  - "\r\r" -> no bin_valid.
  - "12", then rst_n low for 2 cycles, then "7\r" -> bin_out=7, error=0, digit_count=1; all outputs 0 during reset.
